// File: rtl/hnf_rxreq_arb.sv
// Request flit layout shared by the RXREQ ingress and its consumers.
package hnf_rxreq_pkg;
    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [7:0]  txn_id;
        logic [5:0]  opcode;
        logic [47:0] addr;
    } reqflit_t;
endpackage

// Generic circular FIFO with occupancy count.
// Latency: pushed entry visible at head_dat the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module hnf_rxreq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] cnt
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_vld) wptr <= ptr_inc(wptr);
            if (pop_rdy)  rptr <= ptr_inc(rptr);
            if (push_vld && !pop_rdy)      cnt <= cnt + CW'(1);
            else if (!push_vld && pop_rdy) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_vld) mem[wptr] <= push_dat;
    end

    assign head_dat = mem[rptr];
endmodule

// Multi-port CHI RXREQ ingress: per-port L-credit manager + flit FIFO, round-robin merge.
// Latency: 1 cycle from flit sample to req_valid; no bypass path.
// Backpressure: req_ready low holds the winner stable; full FIFOs stop credit issue.
module hnf_rxreq_arb
    import hnf_rxreq_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_CRD   = 15,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  reqflit_t [NUM_PORTS-1:0] RXREQFLIT,
    input  logic [NUM_PORTS-1:0]     RXREQFLITV,
    input  logic [NUM_PORTS-1:0]     RXREQFLITPEND,
    output logic [NUM_PORTS-1:0]     RXREQLCRDV,
    output reqflit_t                 req_flit,
    output logic [PW-1:0]            req_port,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [NUM_PORTS-1:0]     proto_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(MAX_CRD + 1);

    logic                 unused_pend;
    logic [NUM_PORTS-1:0] nonempty;
    reqflit_t             head [NUM_PORTS];
    logic [PW-1:0]        rr;
    logic [PW-1:0]        win;
    logic                 found;
    logic                 xfer;

    assign unused_pend = ^RXREQFLITPEND;
    assign xfer        = req_valid && req_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [CW-1:0] cnt_q;
        logic [KW-1:0] crd_q;
        logic          lcrdv_q;
        logic          err_q;
        logic          rx;
        logic          deq;
        logic          grant;
        logic [31:0]   cnt_nxt;
        logic [31:0]   crd_aft;

        // A flit arriving with no credit held is a protocol violation and is discarded.
        assign rx      = RXREQFLITV[p] && (crd_q != '0);
        assign deq     = xfer && (win == PW'(p));
        assign cnt_nxt = 32'(cnt_q) + 32'(rx) - 32'(deq);
        assign crd_aft = 32'(crd_q) - 32'(rx);
        assign grant   = ((cnt_nxt + crd_aft) < 32'(DEPTH)) && (crd_aft < 32'(MAX_CRD));

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                crd_q   <= '0;
                lcrdv_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                crd_q   <= KW'(crd_aft + 32'(grant));
                lcrdv_q <= grant;
                if (RXREQFLITV[p] && (crd_q == '0)) err_q <= 1'b1;
            end
        end

        hnf_rxreq_fifo #(
            .W     ($bits(reqflit_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push_vld (rx),
            .push_dat (RXREQFLIT[p]),
            .pop_rdy  (deq),
            .head_dat (head[p]),
            .cnt      (cnt_q)
        );

        assign nonempty[p]   = (cnt_q != '0);
        assign RXREQLCRDV[p] = lcrdv_q;
        assign proto_err[p]  = err_q;
    end

    // Search upward from rr with wrap; first non-empty port wins.
    always_comb begin
        logic [PW:0] sum;
        win   = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(NUM_PORTS)) sum = sum - (PW + 1)'(NUM_PORTS);
            if (!found && nonempty[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr <= '0;
        end else if (xfer) begin
            rr <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
        end
    end

    assign req_valid = found;
    assign req_port  = found ? win : '0;
    assign req_flit  = found ? head[win] : '0;
endmodule

// File: tb/tb_hnf_rxreq_arb.sv
// Directed bench for hnf_rxreq_arb: credit ramp, round-robin, backpressure, protocol error, reset.
module tb_hnf_rxreq_arb;
    import hnf_rxreq_pkg::*;

    logic           clock;
    logic           reset;
    reqflit_t [3:0] flit_in;
    logic [3:0]     flitv;
    logic [3:0]     pend;
    logic [3:0]     lcrdv;
    reqflit_t       req_flit;
    logic [1:0]     req_port;
    logic           req_valid;
    logic           req_ready;
    logic [3:0]     proto_err;

    int total = 0;
    int bad   = 0;

    hnf_rxreq_arb #(.NUM_PORTS(4), .DEPTH(4), .MAX_CRD(15)) dut (
        .clock         (clock),
        .reset         (reset),
        .RXREQFLIT     (flit_in),
        .RXREQFLITV    (flitv),
        .RXREQFLITPEND (pend),
        .RXREQLCRDV    (lcrdv),
        .req_flit      (req_flit),
        .req_port      (req_port),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .proto_err     (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic reqflit_t mkflit(input int p, input int k);
        reqflit_t f;
        f.qos    = 4'(p);
        f.tgt_id = 7'h20;
        f.src_id = 7'(p + 1);
        f.txn_id = 8'(16 * p + k);
        f.opcode = 6'h01;
        f.addr   = 48'hA000_0000 + 48'(256 * p + k);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input int p, input reqflit_t f);
        chk({tag, ".valid"}, 128'(req_valid), 128'(v));
        chk({tag, ".port"},  128'(req_port),  128'(p));
        chk({tag, ".flit"},  128'(req_flit),  128'(f));
    endtask

    task automatic ramp_checks(input string tag);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            chk($sformatf("%s.lcrdv.c%0d", tag, c), 128'(lcrdv), (c <= 4) ? 128'hf : 128'h0);
            chk($sformatf("%s.valid.c%0d", tag, c), 128'(req_valid), 128'h0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flit_in   = '0;
        flitv     = '0;
        pend      = '0;
        req_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst.lcrdv", 128'(lcrdv), 128'h0);
        chk_out("rst", 1'b0, 0, '0);
        chk("rst.err", 128'(proto_err), 128'h0);
        reset = 1'b1;
        ramp_checks("ramp");

        // Round robin: two flits on every port, then drain with ready high.
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) flit_in[p] = mkflit(p, k);
            flitv = 4'hf;
            @(negedge clock);
        end
        flitv = '0;
        chk("rr.load.lcrdv", 128'(lcrdv), 128'h0);
        req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk_out($sformatf("rr4.%0d", k), 1'b1, k % 4, mkflit(k % 4, k / 4));
            if (k > 0) chk($sformatf("rr4.lcrdv.%0d", k), 128'(lcrdv), 128'(1 << ((k - 1) % 4)));
            @(negedge clock);
        end
        chk("rr4.end.valid", 128'(req_valid), 128'h0);
        chk("rr4.end.lcrdv", 128'(lcrdv), 128'h8);

        // Ports 1 and 3 only.
        req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            flit_in[1] = mkflit(1, k);
            flit_in[3] = mkflit(3, k);
            flitv = 4'b1010;
            @(negedge clock);
        end
        flitv = '0;
        req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("rr2.%0d", k), 1'b1, (k % 2) ? 3 : 1, mkflit((k % 2) ? 3 : 1, k / 2));
            @(negedge clock);
        end
        chk("rr2.end.valid", 128'(req_valid), 128'h0);

        // Single flit on port 2.
        flit_in[2] = mkflit(2, 5);
        flitv      = 4'b0100;
        @(negedge clock);
        flitv = '0;
        chk_out("single", 1'b1, 2, mkflit(2, 5));
        chk("single.lcrdv0", 128'(lcrdv), 128'h0);
        @(negedge clock);
        chk("single.lcrdv1", 128'(lcrdv), 128'h4);
        chk("single.drained", 128'(req_valid), 128'h0);
        @(negedge clock);
        chk("single.lcrdv2", 128'(lcrdv), 128'h0);

        // Backpressure: four flits on port 0 with ready low.
        req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            flit_in[0] = mkflit(0, k);
            flitv      = 4'b0001;
            @(negedge clock);
            chk_out($sformatf("bp.fill%0d", k), 1'b1, 0, mkflit(0, 0));
        end
        flitv = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk_out($sformatf("bp.hold%0d", c), 1'b1, 0, mkflit(0, 0));
            chk($sformatf("bp.hold.lcrdv%0d", c), 128'(lcrdv), 128'h0);
        end
        req_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            chk_out($sformatf("bp.drain%0d", k), 1'b1, 0, mkflit(0, k));
            chk($sformatf("bp.drain.lcrdv%0d", k), 128'(lcrdv), 128'h1);
        end
        @(negedge clock);
        chk("bp.end.valid", 128'(req_valid), 128'h0);
        chk("bp.end.lcrdv", 128'(lcrdv), 128'h1);
        @(negedge clock);
        chk("bp.end.lcrdv2", 128'(lcrdv), 128'h0);

        // Protocol error: fifth flit on port 1 with no credit left.
        req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            flit_in[1] = mkflit(1, (k == 4) ? 9 : k);
            flitv      = 4'b0010;
            @(negedge clock);
            if (k == 3) chk("perr.before", 128'(proto_err), 128'h0);
        end
        flitv = '0;
        chk("perr.set", 128'(proto_err), 128'h2);
        req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("perr.drain%0d", k), 1'b1, 1, mkflit(1, k));
            @(negedge clock);
            chk($sformatf("perr.lcrdv%0d", k), 128'(lcrdv), 128'h2);
        end
        chk("perr.dropped", 128'(req_valid), 128'h0);
        @(negedge clock);
        chk("perr.sticky", 128'(proto_err), 128'h2);
        chk("perr.lcrdv_end", 128'(lcrdv), 128'h0);

        // Reset mid-stream with three flits buffered on port 2.
        req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flit_in[2] = mkflit(2, k);
            flitv      = 4'b0100;
            @(negedge clock);
        end
        flitv = '0;
        chk_out("mid.pre", 1'b1, 2, mkflit(2, 0));
        #1 reset = 1'b0;
        #1;
        chk_out("mid.rst", 1'b0, 0, '0);
        chk("mid.rst.lcrdv", 128'(lcrdv), 128'h0);
        chk("mid.rst.err", 128'(proto_err), 128'h0);
        @(negedge clock);
        reset = 1'b1;
        ramp_checks("reramp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hnf_rxreq_arb.md
# hnf_rxreq_arb

Multi-port CHI RXREQ ingress for the HN-F. It terminates `NUM_PORTS` independent RXREQ link channels, each with its own receiver-side L-credit manager and `DEPTH`-entry flit FIFO. A fair round-robin arbiter merges the ports onto one valid/ready request stream, tagged with the source port, which feeds the SLC request pipeline and POCQ allocation. It replaces the single-port RXREQ front end so the HN-F can serve several requester links.

## Interface
- `NUM_PORTS`, 4: number of RXREQ link channels (>=1).
- `DEPTH`, 4: flit FIFO entries per port (>=1); also the per-port credit ceiling together with `MAX_CRD`.
- `MAX_CRD`, 15: maximum L-credits outstanding per port (CHI limit, 1..15).
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `RXREQFLIT`  in  NUM_PORTS x $bits(reqflit_t)  per-port request flit.
- `RXREQFLITV`  in  NUM_PORTS  per-port flit valid; each assertion consumes one credit.
- `RXREQFLITPEND`  in  NUM_PORTS  accepted, unused (no clock gating in this block).
- `RXREQLCRDV`  out  NUM_PORTS  per-port L-credit grant pulse, registered.
- `req_flit`  out  $bits(reqflit_t)  arbitrated flit.
- `req_port`  out  $clog2(NUM_PORTS) (min 1)  source port of `req_flit`.
- `req_valid`  out  1  arbitrated flit available.
- `req_ready`  in  1  downstream accept; transfer when `req_valid && req_ready`.
- `proto_err`  out  NUM_PORTS  sticky: flit received on a port holding zero credits.

## Operation
- Per-port state: FIFO count `cnt` (0..DEPTH), outstanding-credit counter `crd` (0..MAX_CRD), FIFO read/write pointers (wrap modulo DEPTH), and sticky `proto_err`.
- Invariant: `cnt + crd <= DEPTH` at all times.
- Credit grant: at each edge, the port registers `RXREQLCRDV=1` for the next cycle iff `cnt_next + crd_next < DEPTH` and `crd_next < MAX_CRD`. Otherwise it registers 0. At most one credit per port per cycle. A grant increments `crd`.
- Flit receive: when `RXREQFLITV[p]=1` and `crd>0`, the flit is written at the write pointer, `cnt` increments and `crd` decrements.
  - If a grant and a receive occur in the same cycle, `crd` is unchanged.
- Flit with `crd==0` is dropped: FIFO and counters are untouched and `proto_err[p]` is set. Only reset clears it.
- Dequeue: the winning port's read pointer advances and its `cnt` decrements on a transfer. Simultaneous receive and dequeue on the same port leaves `cnt` unchanged. FIFO overflow is impossible by the invariant.
- Arbitration:
  - Round-robin over ports with `cnt>0`, searching upward from priority pointer `rr` with wrap.
  - `rr` moves to winner+1 (mod NUM_PORTS) only on a transfer. It holds while `req_valid && !req_ready`.
  - With NUM_PORTS=1, port 0 always wins.
- Output is combinational from registered FIFO state. `req_flit`, `req_port` and `req_valid` remain stable while stalled, because the winner cannot change without a transfer (`rr` holds, and the winner's FIFO cannot drain).

## Timing
- Reset values (async, while `reset=0`): all `cnt`, `crd` and pointers are 0; `rr`=0; `RXREQLCRDV`=0; `req_valid`=0; `req_flit`=0; `req_port`=0; `proto_err`=0.
- After reset release, first edge registers grants, so `RXREQLCRDV[p]=1` in cycle 1. With no traffic, each port pulses for min(DEPTH, MAX_CRD) consecutive cycles, then stays 0.
- Latency: a flit sampled at edge N appears on `req_flit` with `req_valid=1` after edge N (cycle N+1) if its port wins. Minimum latency is 1 cycle and there is no bypass.
- A freed slot (dequeue at edge N) yields a new `RXREQLCRDV` pulse in cycle N+1.
- Steady-state throughput: one flit per cycle aggregate output; each port can sustain one flit per cycle when DEPTH>=2.
- Reset assertion mid-operation immediately clears all state and outputs. Buffered flits and outstanding credits are discarded, and the credit ramp restarts on release.

## Test plan
- Reset ramp: NUM_PORTS=4, DEPTH=4, no traffic. Required: each `RXREQLCRDV[p]` is high in cycles 1-4, then low indefinitely; `req_valid=0`.
- Single flit: after ramp, drive port 2 with flit A for one cycle, `req_ready=1`. Required: next cycle `req_valid=1`, `req_flit=A`, `req_port=2`; one cycle later `RXREQLCRDV[2]` pulses once.
- Round-robin: ports 0-3 each hold 2 flits, `req_ready=1`. Required: `req_port` sequence 0,1,2,3,0,1,2,3. With ports 1 and 3 only, the sequence alternates 1,3,1,3.
- Backpressure: `req_ready=0`, port 0 sends 4 flits. Required: `cnt`=4, no further `RXREQLCRDV[0]`, and output held stable at flit 0. Release `req_ready`: 4 transfers in order, and 4 credit pulses follow.
- Protocol error: port 1 with `crd=0` (after 4 flits with `req_ready=0`) asserts `RXREQFLITV[1]`. Required: flit dropped, `proto_err[1]=1` sticky, other ports unaffected.
- Reset mid-stream: assert `reset=0` with 3 flits buffered and `req_valid=1`. Required: outputs 0 in the same cycle, and after release the ramp repeats as in scenario 1.
